// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: arbitration-side AHB signals shared by the arbiter and the bus fabric
interface ahb_bus_arbiter_if #(parameter int NUM_MASTERS = 4);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [$clog2(NUM_MASTERS)-1:0] hmaster;
  logic hmastlock;
  modport master (output hbusreq, hlock, htrans, hburst, hready, input hgrant, hmaster, hmastlock);
  modport slave (input hbusreq, hlock, htrans, hburst, hready, output hgrant, hmaster, hmastlock);
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter that never breaks fixed bursts or locked sequences
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DEF_MASTER = 0
) (
  input logic clk,
  input logic rst,
  ahb_bus_arbiter_if.slave bus
);
  localparam int W = $clog2(NUM_MASTERS);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [W-1:0] DEF = W'(DEF_MASTER);
  logic [W-1:0] gnt_q, gnt_d, mst_q, mst_d, ptr_q, ptr_d, win;
  logic [4:0] rem_q, rem_d, len;
  logic lock_q, lock_d, arb, locked_owner, found;
  int j;
  always_comb begin
    len = bus.hburst < 3'd2 ? 5'd1 : bus.hburst < 3'd4 ? 5'd4 : bus.hburst < 3'd6 ? 5'd8 : 5'd16;
    locked_owner = bus.hlock[mst_q] & bus.hbusreq[mst_q];
    arb = bus.hready & !locked_owner & (bus.htrans == IDLE || (bus.htrans == BUSY && rem_q == 5'd0) ||
          (bus.htrans == NONSEQ && len == 5'd1) || (bus.htrans == SEQ && rem_q == 5'd1));
  end
  // the current owner is skipped in the scan and only re-wins when nobody else asks
  always_comb begin
    win = DEF;
    found = 1'b0;
    j = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = (int'(ptr_q) + i) % NUM_MASTERS;
      if (!found && bus.hbusreq[j] && j != int'(mst_q)) begin
        win = W'(j);
        found = 1'b1;
      end
    end
    if (!found) win = bus.hbusreq[mst_q] ? mst_q : DEF;
  end
  always_comb begin
    gnt_d = arb ? win : gnt_q;
    ptr_d = arb && (found || bus.hbusreq[mst_q]) ? win : ptr_q;
    mst_d = bus.hready ? gnt_q : mst_q;
    lock_d = bus.hready ? bus.hlock[gnt_q] & bus.hbusreq[gnt_q] : lock_q;
    rem_d = !bus.hready ? rem_q :
            bus.htrans == NONSEQ ? len - 5'd1 :
            bus.htrans == SEQ ? (rem_q == 5'd0 ? 5'd0 : rem_q - 5'd1) :
            bus.htrans == IDLE ? 5'd0 : rem_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= DEF;
      mst_q <= DEF;
      ptr_q <= DEF;
      lock_q <= 1'b0;
      rem_q <= 5'd0;
    end else begin
      gnt_q <= gnt_d;
      mst_q <= mst_d;
      ptr_q <= ptr_d;
      lock_q <= lock_d;
      rem_q <= rem_d;
    end
  end
  assign bus.hgrant = NUM_MASTERS'(1) << gnt_q;
  assign bus.hmaster = mst_q;
  assign bus.hmastlock = lock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed vector table plus a mid-burst reset sequence
module tb_ahb_bus_arbiter;
  localparam logic [1:0] I = 2'd0, B = 2'd1, N = 2'd2, S = 2'd3;
  typedef struct packed {
    logic rst;
    logic [3:0] req;
    logic [3:0] lck;
    logic [1:0] tr;
    logic [2:0] bu;
    logic rdy;
    logic [3:0] eg;
    logic [1:0] em;
    logic el;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  vec_t tbl[$];
  ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();
  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEF_MASTER(0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] l, input logic [1:0] t,
                              input logic [2:0] u, input logic y, input logic [3:0] g, input logic [1:0] m, input logic k);
    vec_t v;
    v = '{rst: r, req: q, lck: l, tr: t, bu: u, rdy: y, eg: g, em: m, el: k};
    return v;
  endfunction
  task automatic step(input vec_t v, input string nm);
    rst = v.rst;
    bus.hbusreq = v.req;
    bus.hlock = v.lck;
    bus.htrans = v.tr;
    bus.hburst = v.bu;
    bus.hready = v.rdy;
    @(posedge clk);
    #1;
    total += 4;
    if (bus.hgrant !== v.eg) begin bad++; $display("FAIL %s hgrant got=%b want=%b", nm, bus.hgrant, v.eg); end
    if (bus.hmaster !== v.em) begin bad++; $display("FAIL %s hmaster got=%0d want=%0d", nm, bus.hmaster, v.em); end
    if (bus.hmastlock !== v.el) begin bad++; $display("FAIL %s hmastlock got=%b want=%b", nm, bus.hmastlock, v.el); end
    if (!$onehot(bus.hgrant)) begin bad++; $display("FAIL %s onehot got=%b want=one-hot", nm, bus.hgrant); end
  endtask
  initial begin
    bus.hbusreq = '0;
    bus.hlock = '0;
    bus.htrans = I;
    bus.hburst = 3'd0;
    bus.hready = 1'b1;
    // reset and parking on the default master
    tbl.push_back(mk(1, 4'b0000, 4'b0000, I, 0, 1, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, I, 0, 1, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, I, 0, 1, 4'b0001, 0, 0));
    // all masters request SINGLE transfers: grant rotates, hmaster trails by one
    tbl.push_back(mk(0, 4'b1111, 4'b0000, N, 0, 1, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, N, 0, 1, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, N, 0, 1, 4'b1000, 2, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, N, 0, 1, 4'b0001, 3, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, N, 0, 1, 4'b0010, 0, 0));
    // master 1 INCR8 with master 2 waiting
    tbl.push_back(mk(0, 4'b0010, 4'b0000, I, 0, 1, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0110, 4'b0000, N, 5, 1, 4'b0010, 1, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 4'b0110, 4'b0000, S, 5, 1, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0110, 4'b0000, S, 5, 1, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, I, 0, 1, 4'b0100, 2, 0));
    // same INCR8 with three wait states on beat 4
    tbl.push_back(mk(0, 4'b0010, 4'b0000, I, 0, 1, 4'b0010, 2, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, I, 0, 1, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0110, 4'b0000, N, 5, 1, 4'b0010, 1, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 4'b0110, 4'b0000, S, 5, 1, 4'b0010, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0110, 4'b0000, S, 5, 0, 4'b0010, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0110, 4'b0000, S, 5, 1, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0110, 4'b0000, S, 5, 1, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, I, 0, 1, 4'b0100, 2, 0));
    // master 3 locked while everyone else requests, then releases
    tbl.push_back(mk(0, 4'b1000, 4'b1000, I, 0, 1, 4'b1000, 2, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, I, 0, 1, 4'b1000, 3, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, N, 0, 1, 4'b1000, 3, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, N, 0, 1, 4'b1000, 3, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, N, 0, 1, 4'b0001, 3, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, I, 0, 1, 4'b0001, 0, 0));
    foreach (tbl[k]) step(tbl[k], $sformatf("vec[%0d]", k));
    // reset in the middle of an INCR16 owned by master 1 (rem=9 at the reset edge)
    step(mk(0, 4'b0010, 4'b0000, I, 0, 1, 4'b0010, 0, 0), "rst_seq_grant1");
    step(mk(0, 4'b0010, 4'b0000, I, 0, 1, 4'b0010, 1, 0), "rst_seq_own1");
    step(mk(0, 4'b0110, 4'b0000, N, 7, 1, 4'b0010, 1, 0), "rst_seq_nonseq");
    for (int i = 0; i < 6; i++) step(mk(0, 4'b0110, 4'b0000, S, 7, 1, 4'b0010, 1, 0), $sformatf("rst_seq_seq%0d", i));
    step(mk(1, 4'b0110, 4'b0000, S, 7, 1, 4'b0001, 0, 0), "rst_seq_reset");
    // BUSY re-arbitrates only if rem was cleared; ptr=0 makes master 1 the winner
    step(mk(0, 4'b0110, 4'b0000, B, 7, 1, 4'b0010, 0, 0), "rst_seq_busy_arb");
    step(mk(0, 4'b0000, 4'b0000, I, 0, 1, 4'b0001, 1, 0), "rst_seq_park");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin AHB bus arbiter for up to NUM_MASTERS requesting masters sharing one AHB address/data bus.
- Sits beside the AHB master mux. Drives HGRANT/HMASTER/HMASTLOCK, which steer the mux and feed the bus coverage collector.
- Guarantees fixed-length bursts and locked sequences are never broken by re-arbitration.
- Parks the bus on a default master when nobody requests.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEF_MASTER, 0, index granted when no hbusreq bit is set (0..NUM_MASTERS-1)

Ports:
clk  input  1  bus clock
rst  input  1  synchronous, active-high reset
hbusreq  input  NUM_MASTERS  per-master bus request
hlock  input  NUM_MASTERS  per-master lock request, valid with hbusreq
htrans  input  2  muxed HTRANS of current address-phase owner (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
hburst  input  3  muxed HBURST (0 SINGLE, 1 INCR, 2/3 WRAP4/INCR4, 4/5 WRAP8/INCR8, 6/7 WRAP16/INCR16)
hready  input  1  bus HREADY
hgrant  output  NUM_MASTERS  one-hot grant
hmaster  output  $clog2(NUM_MASTERS)  index of current address-phase owner
hmastlock  output  1  current address-phase transfer is locked

Behaviour:
- Reset (rst=1 at posedge): hgrant = one-hot(DEF_MASTER), hmaster = DEF_MASTER, hmastlock = 0, beat counter = 0, round-robin pointer = DEF_MASTER. Reset mid-burst abandons the burst immediately.
- Beat counter rem (5 bits) tracks beats left in a fixed-length burst.
  - On a posedge with hready=1 and htrans=NONSEQ: rem <= len-1.
  - len = 4/8/16 for WRAPx/INCRx; len = 1 for SINGLE and INCR.
  - Undefined-length INCR is re-arbitrable every beat.
  - hready=1 and htrans=SEQ: rem <= rem-1, saturating at 0.
  - hready=1 and htrans=IDLE: rem <= 0.
  - BUSY, or hready=0: rem holds.
- Arbitration point ARB (combinational) = hready=1 AND NOT locked_owner AND any of:
  - htrans=IDLE
  - htrans=BUSY with rem=0
  - htrans=NONSEQ with len=1
  - htrans=SEQ with rem=1
- ARB marks the last address phase of the burst, so the new owner drives the next address phase.
- locked_owner = hlock[owner] AND hbusreq[owner], where owner = hmaster. A locked owner keeps the grant until it drops hlock, then re-arbitrates at the next ARB.
- Winner selection at ARB:
  - Search hbusreq starting at (ptr+1) mod NUM_MASTERS, wrapping; first set bit wins.
  - If no bit is set, the winner is DEF_MASTER.
  - The current owner may win again only if no other master requests.
  - hgrant <= one-hot(winner) at that posedge. ptr <= winner only when the winner came from a real request.
- hgrant is otherwise held. A master dropping hbusreq mid fixed burst does not remove its grant before ARB.
- Ownership handover:
  - On any posedge with hready=1: hmaster <= index(hgrant), hmastlock <= hlock[index(hgrant)] AND hbusreq[index(hgrant)].
  - Net effect: grant change at edge k, ownership change at the first hready=1 edge after k. Latency is 1 cycle with zero wait states.
- hready=0 freezes hgrant, hmaster, hmastlock, rem and ptr.
- Early termination (NONSEQ or IDLE before rem reaches 0) resets rem per the rules above. No error is flagged.
- hgrant is always exactly one-hot, including during reset and while no master requests.

Test Plan:
- Reset, then hbusreq=0000 -> hgrant=0001, hmaster=0, hmastlock=0 and holding.
- hbusreq=1111, all SINGLE NONSEQ, hready=1 every cycle -> grant rotates 0010, 0100, 1000, 0001, one per cycle. hmaster trails hgrant by 1 cycle.
- Master 1 INCR8 (NONSEQ + 7 SEQ) while master 2 requests from cycle 1 -> hgrant stays 0010 until SEQ with rem=1 (8th address phase), then 0100. hmaster=2 on the next cycle.
- Same INCR8 with hready=0 inserted for 3 cycles on beat 4 -> handover delayed by exactly 3 cycles; no grant change while hready=0.
- Master 3 hlock=1 doing SINGLE transfers, others requesting -> hgrant stays 1000 and hmastlock=1. Drop hlock -> next ARB grants master 0 and hmastlock returns to 0 one cycle later.
- rst asserted mid INCR16 (rem=9) -> next cycle hgrant=0001, hmaster=0, rem=0. Arbitration resumes from ptr=DEF_MASTER.
